// File: rtl/sha256_kt_seq.sv
// Read-side sequencer for the SHA-256 Kt constant BRAM: sweeps the round
// address per block and delays round tags to line up with the BRAM output.
module sha256_kt_seq #(
    parameter int N_CYCLES = 72,
    parameter int RD_LAT   = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic       kt_en,
    output logic [6:0] kt_t,
    output logic       kt_wr_en,
    output logic       kt_wr_addr,
    output logic       rnd_valid,
    output logic [6:0] rnd,
    output logic       rnd_first,
    output logic       rnd_last
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [6:0] T_LAST = 7'(N_CYCLES - 1);

    state_e                  state_q, state_d;
    logic                    kt_en_q, kt_en_d;
    logic [6:0]              kt_t_q, kt_t_d;
    logic [RD_LAT-1:0]       vld_q, vld_d;
    logic [RD_LAT-1:0][6:0]  idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        kt_en_d = kt_en_q;
        kt_t_d  = kt_t_q;
        unique case (state_q)
            S_IDLE: begin
                kt_en_d = start;
                kt_t_d  = 7'd0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (kt_t_q != T_LAST) begin
                    kt_t_d = kt_t_q + 7'd1;
                end else if (start) begin
                    kt_t_d  = 7'd0;
                    kt_en_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    kt_en_d = 1'b0;
                    kt_t_d  = 7'd0;
                end
            end
        endcase
    end

    // Index stages only load on a valid tag so rnd holds between sweeps.
    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = kt_en_q;
        if (kt_en_q) begin
            idx_d[0] = kt_t_q;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                idx_d[i] = idx_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            kt_en_q <= 1'b0;
            kt_t_q  <= 7'd0;
            vld_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            kt_en_q <= kt_en_d;
            kt_t_q  <= kt_t_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign ready      = (state_q == S_IDLE) |
                        ((state_q == S_RUN) & (kt_t_q == T_LAST));
    assign busy       = (state_q == S_RUN) | (|vld_q);
    assign kt_en      = kt_en_q;
    assign kt_t       = kt_t_q;
    assign kt_wr_en   = 1'b0;
    assign kt_wr_addr = 1'b0;
    assign rnd_valid  = vld_q[RD_LAT-1];
    assign rnd        = idx_q[RD_LAT-1];
    assign rnd_first  = rnd_valid & (rnd == 7'd0);
    assign rnd_last   = rnd_valid & (rnd == T_LAST);

endmodule

// File: tb/tb_sha256_kt_seq.sv
// Scoreboard bench for sha256_kt_seq with a queue-based sweep model
// and a behavioural 2-cycle Kt BRAM.
module tb_sha256_kt_seq;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready, busy, kt_en, kt_wr_en, kt_wr_addr;
    logic [6:0] kt_t, rnd;
    logic       rnd_valid, rnd_first, rnd_last;

    sha256_kt_seq dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .busy       (busy),
        .kt_en      (kt_en),
        .kt_t       (kt_t),
        .kt_wr_en   (kt_wr_en),
        .kt_wr_addr (kt_wr_addr),
        .rnd_valid  (rnd_valid),
        .rnd        (rnd),
        .rnd_first  (rnd_first),
        .rnd_last   (rnd_last)
    );

    always #5 CLK = ~CLK;

    logic [31:0] kc [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Round table: 7 leading zero entries, 64 constants, one trailing zero.
    function automatic logic [31:0] kfun(input int t);
        if (t >= 7 && t <= 70) return kc[t-7];
        return 32'd0;
    endfunction

    // Behavioural BRAM: registered read plus output register, zeroed when idle.
    logic [31:0] br1 = '0;
    logic [31:0] kt  = '0;
    logic        en1 = 1'b0;
    always @(posedge CLK) begin
        br1 <= kt_en ? kfun(int'(kt_t)) : 32'd0;
        en1 <= kt_en;
        kt  <= en1 ? br1 : 32'd0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int t;
        int due;
    } tag_t;

    int   pend[$];
    tag_t exp_q[$];
    bit   m_en = 1'b0;
    int   m_t = 0;
    int   last_rnd = 0;
    bit   armed = 1'b0;

    // Model: an accepted start schedules 72 addresses; ready means nothing is left to issue.
    always @(posedge CLK) begin
        tag_t e;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            m_en = 1'b0;
            m_t = 0;
            last_rnd = 0;
            armed = 1'b1;
        end else begin
            if (start && pend.size() == 0) begin
                for (int i = 0; i < 72; i++) pend.push_back(i);
            end
            if (pend.size() > 0) begin
                m_t = pend.pop_front();
                m_en = 1'b1;
                e.t = m_t;
                e.due = cyc + 2;
                exp_q.push_back(e);
            end else begin
                m_en = 1'b0;
                m_t = 0;
            end
        end
    end

    always @(negedge CLK) begin
        tag_t e;
        if (armed) begin
            chk("kt_en", kt_en, m_en);
            chk("kt_t", kt_t, m_t);
            chk("ready", ready, pend.size() == 0);
            chk("busy", busy, m_en || exp_q.size() > 0);
            chk("kt_wr_en", kt_wr_en, 0);
            chk("kt_wr_addr", kt_wr_addr, 0);
            if (rnd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_unexpected: got rnd %0d expected none (cycle %0d)",
                             rnd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_time", cyc, e.due);
                    chk("rnd", rnd, e.t);
                    chk("rnd_first", rnd_first, e.t == 0);
                    chk("rnd_last", rnd_last, e.t == 71);
                    chk("kt", kt, kfun(e.t));
                    last_rnd = e.t;
                end
            end else begin
                chk("rnd_hold", rnd, last_rnd);
                chk("rnd_first_idle", rnd_first, 0);
                chk("rnd_last_idle", rnd_last, 0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL rnd_missing: got rnd_valid 0 expected rnd %0d (cycle %0d)",
                             e.t, cyc);
                end
            end
        end
    end

    a_rng: assert property (@(posedge CLK) disable iff (rst)
                            rnd_valid |-> rnd <= 7'd71)
        else begin
            errors++;
            $display("FAIL rnd_range: got %0d expected <= 71", rnd);
        end

    a_last: assert property (@(posedge CLK) disable iff (rst)
                             rnd_last |=> !rnd_last)
        else begin
            errors++;
            $display("FAIL rnd_last_twice: got 1 expected 0");
        end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int dense;
        rst = 1'b1;
        start = 1'b1;
        cycles(3);
        rst = 1'b0;
        start = 1'b0;
        cycles(5);

        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(80);

        start = 1'b1;
        cycles(150);
        start = 1'b0;
        cycles(80);

        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(30);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(80);

        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(40);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(3);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(80);

        dense = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dense = $urandom_range(0, 1);
            start = dense ? ($urandom_range(0, 3) != 0)
                          : ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        start = 1'b0;
        rst = 1'b0;
        cycles(80);
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
